// File: rtl/spi_master_ctrl_if.sv
// Control/status and serial-line bundle between the memory-mapped SPI core and spi_master_ctrl.
// The lsb_first signal exists only when SPI_MASTER_LSB_FIRST_EN is defined.
interface spi_master_ctrl_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] din;
    logic [15:0]  dvsr;
    logic         start;
    logic         cpol;
    logic         cpha;
    logic         miso;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic         lsb_first;
`endif
    logic [W-1:0] dout;
    logic         sclk;
    logic         mosi;
    logic         spi_done_tick;
    logic         ready;

    // Engine side.
    modport master (
`ifdef SPI_MASTER_LSB_FIRST_EN
        input  lsb_first,
`endif
        input  din,
        input  dvsr,
        input  start,
        input  cpol,
        input  cpha,
        input  miso,
        output dout,
        output sclk,
        output mosi,
        output spi_done_tick,
        output ready
    );

    // Register-core / slave-device side.
    modport slave (
`ifdef SPI_MASTER_LSB_FIRST_EN
        output lsb_first,
`endif
        output din,
        output dvsr,
        output start,
        output cpol,
        output cpha,
        output miso,
        input  dout,
        input  sclk,
        input  mosi,
        input  spi_done_tick,
        input  ready
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master engine: one W-bit transfer per start, all four SPI modes, sclk divider.
// Defining SPI_MASTER_LSB_FIRST_EN adds run-time selectable LSB-first bit ordering.
module spi_master_ctrl #(
    parameter int unsigned W = 8
) (
    input logic               clk,
    input logic               reset_n,
    spi_master_ctrl_if.master bus
);
    localparam int unsigned   BW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LastBit = BW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCphaDly,
        StP0,
        StP1
    } state_e;

    state_e        state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   dvsr_q;
    logic [BW-1:0] bit_q;
    logic [W-1:0]  tx_q;
    logic [W-1:0]  rx_q;
    logic [W-1:0]  dout_q;
    logic          cpol_q;
    logic          cpha_q;
    logic          sclk_q;
    logic          lsb_sel;
    logic          half_end;
    logic          last_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q;
    assign lsb_sel = lsb_q;
`else
    assign lsb_sel = 1'b0;
`endif

    // Equality compare lets dvsr = 16'hFFFF wrap the counter cleanly to zero.
    assign half_end = (cnt_q == dvsr_q);
    assign last_bit = (bit_q == LastBit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvsr_q  <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Idle sclk follows the live cpol; the accepted transfer starts at cpol too.
                    sclk_q <= bus.cpol;
                    if (bus.start) begin
                        tx_q   <= bus.din;
                        dvsr_q <= bus.dvsr;
                        cpol_q <= bus.cpol;
                        cpha_q <= bus.cpha;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        lsb_q  <= bus.lsb_first;
`endif
                        cnt_q  <= '0;
                        bit_q  <= '0;
                        if (bus.cpha) begin
                            state_q <= StCphaDly;
                        end else begin
                            state_q <= StP0;
                        end
                    end
                end

                StCphaDly: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= StP0;
                        sclk_q  <= cpha_q ^ cpol_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StP0: begin
                    if (half_end) begin
                        if (lsb_sel) begin
                            rx_q <= {bus.miso, rx_q[W-1:1]};
                        end else begin
                            rx_q <= {rx_q[W-2:0], bus.miso};
                        end
                        cnt_q   <= '0;
                        state_q <= StP1;
                        sclk_q  <= ~cpha_q ^ cpol_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StP1: begin
                    if (half_end) begin
                        cnt_q <= '0;
                        if (last_bit) begin
                            dout_q  <= rx_q;
                            state_q <= StIdle;
                            sclk_q  <= bus.cpol;
                        end else begin
                            if (lsb_sel) begin
                                tx_q <= tx_q >> 1;
                            end else begin
                                tx_q <= tx_q << 1;
                            end
                            bit_q   <= bit_q + BW'(1);
                            state_q <= StP0;
                            sclk_q  <= cpha_q ^ cpol_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.dout          = dout_q;
    assign bus.sclk          = sclk_q;
    assign bus.mosi          = lsb_sel ? tx_q[0] : tx_q[W-1];
    assign bus.ready         = (state_q == StIdle);
    assign bus.spi_done_tick = (state_q == StP1) && half_end && last_bit;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: cycle-accurate transfer model plus directed literals.
// Exercises the LSB-first path too when SPI_MASTER_LSB_FIRST_EN is defined.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    localparam int unsigned W = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.W(W)) bus ();

    spi_master_ctrl #(.W(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer model: position j counts clk edges since the accepting edge.
    bit           m_busy      = 1'b0;
    bit           m_fresh     = 1'b1;
    logic         m_idle_sclk = 1'b0;
    int           m_j, m_h, m_lead, m_len;
    logic [W-1:0] m_din;
    logic [W-1:0] m_word;
    logic [W-1:0] m_dout      = '0;
    logic         m_cpol, m_cpha;
    bit           m_lsb       = 1'b0;

    bit           loopback    = 1'b0;
    logic [W-1:0] slave_word  = '0;
    int           cyc         = 0;
    int           accept_cyc  = 0;
    int           done_cyc    = 0;
    int           done_cnt    = 0;
    int           rise_cnt    = 0;
    logic         prev_sclk   = 1'b0;
    logic [W-1:0] mosi_cap    = '0;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_dout  = '0;
            m_fresh = 1'b1;
        end else begin
            m_fresh     = 1'b0;
            m_idle_sclk = bus.cpol;
            if (m_busy) begin
                m_j++;
                if (m_j == m_len) begin
                    m_busy = 1'b0;
                    m_dout = m_word;
                end
            end else if (bus.start) begin
                m_busy     = 1'b1;
                m_j        = 0;
                m_din      = bus.din;
                m_cpol     = bus.cpol;
                m_cpha     = bus.cpha;
                m_h        = int'(bus.dvsr) + 1;
                m_lead     = bus.cpha ? m_h : 0;
                m_len      = 2 * W * m_h + m_lead;
                m_word     = loopback ? bus.din : slave_word;
                accept_cyc = cyc;
`ifdef SPI_MASTER_LSB_FIRST_EN
                m_lsb      = bus.lsb_first;
`endif
            end
        end
    end

    // Compare process and slave miso driver, both on the falling edge.
    always @(negedge clk) begin
        int   p, half, b;
        logic e_sclk, e_mosi, s_bit;
        check("dout", bus.dout, m_dout);
        if (m_busy) begin
            p = m_j - m_lead;
            if (p < 0) begin
                e_sclk = m_cpol;
                b      = 0;
            end else begin
                half   = p / m_h;
                b      = half / 2;
                e_sclk = ((half % 2 == 1) ? ~m_cpha : m_cpha) ^ m_cpol;
                if (p % (2 * m_h) == 0) mosi_cap = {mosi_cap[W-2:0], bus.mosi};
            end
            e_mosi = m_lsb ? m_din[b] : m_din[W-1-b];
            s_bit  = m_lsb ? m_word[b] : m_word[W-1-b];
            check("ready_busy", bus.ready, 1'b0);
            check("sclk_busy", bus.sclk, e_sclk);
            check("mosi_busy", bus.mosi, e_mosi);
            check("done_tick", bus.spi_done_tick, (m_j == m_len - 1));
            bus.miso = loopback ? bus.mosi : s_bit;
        end else begin
            check("ready_idle", bus.ready, 1'b1);
            check("sclk_idle", bus.sclk, m_fresh ? 1'b0 : m_idle_sclk);
            check("done_idle", bus.spi_done_tick, 1'b0);
            if (m_fresh) check("mosi_reset", bus.mosi, 1'b0);
            bus.miso = 1'b0;
        end
        if (bus.spi_done_tick) begin
            done_cnt++;
            done_cyc = cyc + 1;
        end
        if (bus.sclk && !prev_sclk) rise_cnt++;
        prev_sclk = bus.sclk;
    end

    task automatic start_xfer(input logic [W-1:0] d, input logic [15:0] dv,
                              input logic pol, input logic pha);
        @(negedge clk);
        bus.din   = d;
        bus.dvsr  = dv;
        bus.cpol  = pol;
        bus.cpha  = pha;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready && n < bound);
        check("ready_timeout", bus.ready, 1'b1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.spi_done_tick && n < bound);
        check("done_timeout", bus.spi_done_tick, 1'b1);
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        rise_cnt = 0;
        mosi_cap = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.din   = '0;
        bus.dvsr  = '0;
        bus.start = 1'b0;
        bus.cpol  = 1'b0;
        bus.cpha  = 1'b0;
        bus.miso  = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        #1;
        check("rst_ready", bus.ready, 1'b1);
        check("rst_sclk", bus.sclk, 1'b0);
        check("rst_mosi", bus.mosi, 1'b0);
        check("rst_dout", bus.dout, '0);
        check("rst_done", bus.spi_done_tick, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // Mode 0, dvsr 0, loopback of A5.
        loopback = 1'b1;
        clear_stats();
        start_xfer(8'hA5, 16'd0, 1'b0, 1'b0);
        wait_ready(100);
        check("m0_dout", bus.dout, 8'hA5);
        check("m0_len", done_cyc - accept_cyc, 16);
        check("m0_rises", rise_cnt, 8);
        check("m0_done_cnt", done_cnt, 1);
        check("m0_idle_low", bus.sclk, 1'b0);

        // Mode 3, dvsr 3, slave answers 96.
        loopback   = 1'b0;
        slave_word = 8'h96;
        @(negedge clk);
        bus.cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("m3_idle_high_pre", bus.sclk, 1'b1);
        clear_stats();
        start_xfer(8'h3C, 16'd3, 1'b1, 1'b1);
        wait_ready(200);
        check("m3_mosi_stream", mosi_cap, 8'h3C);
        check("m3_dout", bus.dout, 8'h96);
        check("m3_len", done_cyc - accept_cyc, 68);
        check("m3_idle_high_post", bus.sclk, 1'b1);

        // Mode 1: start mid-transfer and coincident with done are both ignored.
        slave_word = 8'hC3;
        clear_stats();
        start_xfer(8'h5A, 16'd1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.din   = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(200);
        bus.din    = 8'h81;
        slave_word = 8'h3E;
        bus.start  = 1'b1;
        @(negedge clk);
        check("coinc_start_ignored", bus.ready, 1'b1);
        check("coinc_done_cnt", done_cnt, 1);
        check("coinc_dout", bus.dout, 8'hC3);
        @(negedge clk);
        bus.start = 1'b0;
        check("start_one_later", bus.ready, 1'b0);
        wait_ready(200);
        check("second_dout", bus.dout, 8'h3E);
        check("second_done_cnt", done_cnt, 2);

        // Mode 2: inputs disturbed mid-transfer must not alter the transfer.
        slave_word = 8'hD2;
        clear_stats();
        start_xfer(8'h69, 16'd2, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        bus.cpol = 1'b0;
        bus.cpha = 1'b1;
        bus.dvsr = 16'd7;
        bus.din  = 8'h00;
        wait_ready(200);
        check("m2_len", done_cyc - accept_cyc, 48);
        check("m2_dout", bus.dout, 8'hD2);
        check("m2_rises", rise_cnt, 8);

        // Reset during bit 4 aborts cleanly.
        loopback = 1'b1;
        clear_stats();
        start_xfer(8'hC5, 16'd1, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ready", bus.ready, 1'b1);
        check("abort_sclk", bus.sclk, 1'b0);
        check("abort_mosi", bus.mosi, 1'b0);
        check("abort_dout", bus.dout, '0);
        check("abort_done", bus.spi_done_tick, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        check("abort_no_tick", done_cnt, 0);
        start_xfer(8'h3A, 16'd0, 1'b0, 1'b0);
        wait_ready(100);
        check("post_abort_dout", bus.dout, 8'h3A);
        check("post_abort_done_cnt", done_cnt, 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
        bus.lsb_first = 1'b1;
        clear_stats();
        start_xfer(8'h01, 16'd0, 1'b0, 1'b0);
        check("lsb_first_mosi", mosi_cap[0], 1'b1);
        bus.lsb_first = 1'b0;
        wait_ready(100);
        check("lsb_dout", bus.dout, 8'h01);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Byte-wide SPI master engine that serialises one 8-bit word per transfer in any of the four SPI modes, with a programmable sclk divider. It sits directly downstream of the memory-mapped SPI core: that core's write/control registers drive `din`, `dvsr`, `cpol`, `cpha` and `start`, and it reads back `dout` and `ready`. Slave-select is not handled here; the core above owns it.

## Interface
- `W`, default 8: data width per transfer, in bits.
- `clk` input 1: system clock. All logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `din` input W: transmit word, sampled on the accepting `start` edge.
- `dvsr` input 16: half-period divisor. Each sclk half-period is `dvsr+1` clk cycles.
- `start` input 1: request a transfer. Honoured only while `ready`=1.
- `cpol` input 1: sclk idle level.
- `cpha` input 1: 0 = sample on the leading edge; 1 = sample on the trailing edge.
- `miso` input 1: serial data from the slave.
- `dout` output W: last received word. Held until the next transfer completes.
- `sclk` output 1: serial clock, registered.
- `mosi` output 1: serial data to the slave. Driven from the shift-register MSB.
- `spi_done_tick` output 1: one-clk pulse in the final cycle of a transfer.
- `ready` output 1: high when idle and able to accept `start`.

## Operation
- FSM states: IDLE, CPHA_DLY, P0, P1.
- IDLE
  - `ready`=1; `sclk` is driven to the live `cpol`.
  - On `start`:
    - Latch `din` into the tx shift register.
    - Latch `dvsr`, `cpol` and `cpha`. Later input changes have no effect until the transfer ends.
    - Clear the divider counter and bit counter.
    - Go to CPHA_DLY if `cpha`=1, else P0.
- CPHA_DLY: `sclk`=cpol for `dvsr+1` clks, then go to P0. This provides the half-period lead-in for modes 1 and 3.
- P0 (data-valid half)
  - Runs `dvsr+1` clks.
  - On the last clk, shift `miso` into the rx register LSB-side, then go to P1.
- P1
  - Runs `dvsr+1` clks.
  - On the last clk, if bit counter = W-1:
    - Assert `spi_done_tick`.
    - Copy the rx register to `dout`.
    - Go to IDLE.
  - Otherwise: shift tx left by one, increment the bit counter, go to P0.
- sclk generation
  - pclk = (P1 & ~cpha) | (P0 & cpha).
  - `sclk` = pclk XOR cpol.
  - Registered from next-state, so `sclk` edges coincide with state transitions.
- Divider counter is 16 bits and compares for equality with the latched `dvsr`. `dvsr`=16'hFFFF is legal and gives a 65536-clk half-period with no overflow.
- `start` while not ready is ignored. It is neither queued nor flagged.
- Asserting `start` in the same cycle as `spi_done_tick` is ignored. It is accepted one cycle later.

## Timing
- Reset values:
  - State IDLE.
  - `ready`=1, `sclk`=0, `mosi`=0, `dout`=0, `spi_done_tick`=0.
  - tx and rx registers and both counters = 0.
- Reset is honoured at any time. A transfer in progress is aborted immediately; there is no partial `dout` update and no done tick.
- `ready` falls on the clk edge that accepts `start`.
- `spi_done_tick` and the `dout` update occur on the edge closing the final P1. `ready` rises one clk later (state IDLE).
- Transfer length, from the accepting edge to the done edge: 2·W·(dvsr+1) clks, plus (dvsr+1) if `cpha`=1.
- First `mosi` bit is valid the clk after `start` is accepted. For `cpha`=0 it is therefore valid a full half-period before the first sclk edge.

## Configuration
- Macro `SPI_MASTER_LSB_FIRST_EN`.
- Defined:
  - Adds input `lsb_first` (1 bit), latched at `start` like the other inputs.
  - When the latched value is 1, tx shifts right with `mosi` = tx[0], and rx fills from the MSB side.
  - Bytes are then sent and received LSB-first.
- Undefined: no `lsb_first` port; always MSB-first.

## Test plan
- Mode 0, `dvsr`=0, `din`=8'hA5, `miso` looped from `mosi`:
  - `dout`=8'hA5.
  - `spi_done_tick` exactly 16 clks after the accepting edge.
  - sclk shows 8 rising edges, idle low.
- Mode 3, `dvsr`=3, `din`=8'h3C, slave model returns 8'h96:
  - `mosi` stream 0,0,1,1,1,1,0,0; `dout`=8'h96.
  - Done at 68 clks.
  - sclk idle high before and after.
- `start` pulsed mid-transfer and again coincident with `spi_done_tick`:
  - Both ignored; one done tick only.
  - A `start` one clk later is accepted.
- `cpol`, `cpha`, `dvsr` and `din` changed during a transfer: the waveform and the transfer count are unaffected.
- `reset_n` low at bit 4:
  - All outputs reach their reset values immediately; no done tick.
  - The next transfer completes normally.
- With `SPI_MASTER_LSB_FIRST_EN` defined, `lsb_first`=1, `din`=8'h01, loopback: first `mosi` bit is 1, `dout`=8'h01.
